// File: rtl/fifo_cmd_ctrl.sv
// Command sequencer: pops ASCII commands from an FWFT FIFO and merges them with button pulses.
// Optional macro FIFO_CMD_LOWER_EN makes lowercase command letters decode like uppercase ones.
module fifo_cmd_ctrl #(
    parameter int unsigned GAP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_fifo_empty,
    input  logic [7:0] i_fifo_rdata,
    output logic       o_fifo_pop,
    input  logic       i_btn_l_pulse,
    input  logic       i_btn_r_pulse,
    input  logic       i_btn_u_pulse,
    input  logic       i_btn_d_pulse,
    output logic       o_left_pulse,
    output logic       o_right_pulse,
    output logic       o_up_pulse,
    output logic       o_down_pulse,
    output logic       o_clear_pulse,
    output logic       o_mode_sel,
    output logic       o_busy,
    output logic [7:0] o_err_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        EMIT,
        GAP
    } state_t;

    typedef enum logic [2:0] {
        CMD_L,
        CMD_R,
        CMD_U,
        CMD_D,
        CMD_C,
        CMD_M,
        CMD_BAD
    } cmd_t;

    localparam logic [7:0] GAP_LOAD = 8'(GAP_CYCLES - 1);

    function automatic cmd_t decode(input logic [7:0] b);
        logic [7:0] c;
        c = b;
`ifdef FIFO_CMD_LOWER_EN
        // Clearing bit 5 maps the six accepted lowercase letters onto uppercase.
        case (b)
            8'h6C, 8'h72, 8'h75, 8'h64, 8'h63, 8'h6D: c = b & 8'hDF;
            default: c = b;
        endcase
`endif
        case (c)
            8'h4C:   decode = CMD_L;
            8'h52:   decode = CMD_R;
            8'h55:   decode = CMD_U;
            8'h44:   decode = CMD_D;
            8'h43:   decode = CMD_C;
            8'h4D:   decode = CMD_M;
            default: decode = CMD_BAD;
        endcase
    endfunction

    state_t     state_q, state_d;
    logic [7:0] cmd_q, cmd_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] err_q, err_d;
    logic       mode_q, mode_d;
    logic       left_q, left_d;
    logic       right_q, right_d;
    logic       up_q, up_d;
    logic       down_q, down_d;
    logic       clear_q, clear_d;

    cmd_t       cmd_kind;
    logic       btn_any;
    logic       pop;
    logic       cmd_l, cmd_r, cmd_u, cmd_d_dir, cmd_c;

    assign cmd_kind = decode(cmd_q);
    assign btn_any  = i_btn_l_pulse | i_btn_r_pulse | i_btn_u_pulse | i_btn_d_pulse;

    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        gap_d     = gap_q;
        err_d     = err_q;
        mode_d    = mode_q;
        pop       = 1'b0;
        cmd_l     = 1'b0;
        cmd_r     = 1'b0;
        cmd_u     = 1'b0;
        cmd_d_dir = 1'b0;
        cmd_c     = 1'b0;

        case (state_q)
            IDLE: begin
                if (!i_fifo_empty) begin
                    pop     = 1'b1;
                    cmd_d   = i_fifo_rdata;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                case (cmd_kind)
                    CMD_M: begin
                        mode_d  = ~mode_q;
                        gap_d   = GAP_LOAD;
                        state_d = GAP;
                    end
                    CMD_BAD: begin
                        if (err_q != 8'hFF) begin
                            err_d = err_q + 8'd1;
                        end
                        state_d = IDLE;
                    end
                    default: begin
                        // A button pulse this cycle holds the command back so the two never coincide.
                        if (!btn_any) begin
                            cmd_l     = (cmd_kind == CMD_L);
                            cmd_r     = (cmd_kind == CMD_R);
                            cmd_u     = (cmd_kind == CMD_U);
                            cmd_d_dir = (cmd_kind == CMD_D);
                            cmd_c     = (cmd_kind == CMD_C);
                            gap_d     = GAP_LOAD;
                            state_d   = GAP;
                        end
                    end
                endcase
            end
            GAP: begin
                if (gap_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign left_d  = i_btn_l_pulse | cmd_l;
    assign right_d = i_btn_r_pulse | cmd_r;
    assign up_d    = i_btn_u_pulse | cmd_u;
    assign down_d  = i_btn_d_pulse | cmd_d_dir;
    assign clear_d = cmd_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            gap_q   <= '0;
            err_q   <= '0;
            mode_q  <= 1'b0;
            left_q  <= 1'b0;
            right_q <= 1'b0;
            up_q    <= 1'b0;
            down_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            gap_q   <= gap_d;
            err_q   <= err_d;
            mode_q  <= mode_d;
            left_q  <= left_d;
            right_q <= right_d;
            up_q    <= up_d;
            down_q  <= down_d;
            clear_q <= clear_d;
        end
    end

    // Pop is held off while reset is asserted so no byte is consumed and then discarded.
    assign o_fifo_pop    = pop & ~rst;
    assign o_left_pulse  = left_q;
    assign o_right_pulse = right_q;
    assign o_up_pulse    = up_q;
    assign o_down_pulse  = down_q;
    assign o_clear_pulse = clear_q;
    assign o_mode_sel    = mode_q;
    assign o_busy        = (state_q != IDLE);
    assign o_err_cnt     = err_q;

endmodule
